cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 170 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Command FIFO plus issue FSM that drives the CPU RAM/register interface.
// Define CPU_SEQ_ILLEGAL_TRAP_EN to trap ops 110/111 into a sticky err flag.
module cpu_sequencer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [2:0] NOP_OP     = 3'b110
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [17:0] cmd_instr,
    input  logic [31:0] cmd_wdata [0:15],
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data [0:15],
    output logic [2:0]  cpu_op,
    output logic [8:0]  cpu_ram_addr,
    output logic [3:0]  cpu_ram_cnt,
    output logic [1:0]  cpu_reg_sel,
    output logic [31:0] cpu_ram_input [0:15],
    input  logic [31:0] cpu_ram_output [0:15],
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ISSUE    = 2'd1;
    localparam logic [1:0] S_CAPTURE  = 2'd2;
    localparam logic [1:0] S_RSP_WAIT = 2'd3;

    localparam logic [2:0] OP_RD = 3'b100;

    logic [17:0] instr_mem [0:FIFO_DEPTH-1];
    logic [31:0] data_mem  [0:FIFO_DEPTH-1][0:15];

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]   state_q, state_d;
    logic [17:0]  issue_instr_q, issue_instr_d;
    logic [31:0]  issue_data_q [0:15];
    logic [31:0]  issue_data_d [0:15];
    logic         rsp_valid_q, rsp_valid_d;
    logic [31:0]  rsp_data_q [0:15];
    logic [31:0]  rsp_data_d [0:15];
    logic         empty, full, push, pop;
    logic [AW-1:0] rd_idx;

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    logic err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Extra pointer MSB distinguishes full from empty when indices match
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready = ~full;
    assign push = cmd_valid & ~full;
    assign pop = (state_q == S_IDLE) & ~empty;
    assign rd_idx = rd_ptr_q[AW-1:0];

    assign wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    always_comb begin
        state_d       = state_q;
        issue_instr_d = issue_instr_q;
        rsp_valid_d   = rsp_valid_q;
        for (int i = 0; i < 16; i++) begin
            issue_data_d[i] = issue_data_q[i];
            rsp_data_d[i]   = rsp_data_q[i];
        end
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        err_d = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    issue_instr_d = instr_mem[rd_idx];
                    for (int i = 0; i < 16; i++)
                        issue_data_d[i] = data_mem[rd_idx][i];
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
                    if (instr_mem[rd_idx][17:16] == 2'b11)
                        err_d = 1'b1;
                    else
                        state_d = S_ISSUE;
`else
                    state_d = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                state_d = (issue_instr_q[17:15] == OP_RD) ? S_CAPTURE : S_IDLE;
            end
            S_CAPTURE: begin
                for (int i = 0; i < 16; i++)
                    rsp_data_d[i] = cpu_ram_output[i];
                rsp_valid_d = 1'b1;
                state_d     = S_RSP_WAIT;
            end
            default: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        cpu_op = NOP_OP;
        case (state_q)
            S_ISSUE:   cpu_op = issue_instr_q[17:15];
            S_CAPTURE: cpu_op = OP_RD;
            default:   cpu_op = NOP_OP;
        endcase
    end

    assign cpu_reg_sel  = issue_instr_q[14:13];
    assign cpu_ram_addr = issue_instr_q[12:4];
    assign cpu_ram_cnt  = issue_instr_q[3:0];
    assign cpu_ram_input = issue_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy = (state_q != S_IDLE) | ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q[AW-1:0]] <= cmd_instr;
            for (int i = 0; i < 16; i++)
                data_mem[wr_ptr_q[AW-1:0]][i] <= cmd_wdata[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            state_q       <= S_IDLE;
            issue_instr_q <= '0;
            rsp_valid_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                issue_data_q[i] <= '0;
                rsp_data_q[i]   <= '0;
            end
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
            err_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            state_q       <= state_d;
            issue_instr_q <= issue_instr_d;
            rsp_valid_q   <= rsp_valid_d;
            for (int i = 0; i < 16; i++) begin
                issue_data_q[i] <= issue_data_d[i];
                rsp_data_q[i]   <= rsp_data_d[i];
            end
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
            err_q <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus
// randomized traffic against a queue-based command/response model.
module tb_cpu_sequencer;

    localparam int         DEPTH = 4;
    localparam logic [2:0] NOP   = 3'b110;

    typedef struct packed {
        logic [17:0] instr;
        logic [31:0] w0;
        logic [31:0] w15;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [17:0] cmd_instr;
    logic [31:0] cmd_wdata [0:15];
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data [0:15];
    logic [2:0]  cpu_op;
    logic [8:0]  cpu_ram_addr;
    logic [3:0]  cpu_ram_cnt;
    logic [1:0]  cpu_reg_sel;
    logic [31:0] cpu_ram_input [0:15];
    logic [31:0] cpu_ram_output [0:15];
    logic        busy;
    logic        err;

    logic        use_w0 = 1'b0;
    logic [31:0] w0 = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.FIFO_DEPTH(DEPTH), .NOP_OP(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_instr(cmd_instr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .cpu_op(cpu_op), .cpu_ram_addr(cpu_ram_addr),
        .cpu_ram_cnt(cpu_ram_cnt), .cpu_reg_sel(cpu_reg_sel),
        .cpu_ram_input(cpu_ram_input),
        .cpu_ram_output(cpu_ram_output),
        .busy(busy), .err(err)
    );

    function automatic logic [31:0] pat(input logic [8:0] a, input int i);
        logic [3:0] n;
        n = i[3:0];
        return {7'h35, a, 12'h000, n};
    endfunction

    // CPU model: RAM read data is a function of the presented address
    always_comb begin
        for (int i = 0; i < 16; i++)
            cpu_ram_output[i] = pat(cpu_ram_addr, i);
        if (use_w0)
            cpu_ram_output[0] = w0;
    end

    task automatic push(input logic [2:0] op, input logic [8:0] addr,
                        input logic [3:0] cnt, input logic [31:0] w0v);
        cmd_instr = {op, 2'b01, addr, cnt};
        for (int i = 0; i < 16; i++)
            cmd_wdata[i] = $urandom;
        cmd_wdata[0] = w0v;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic apply_reset();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (cpu_op !== NOP || cmd_ready !== 1'b1 || busy !== 1'b0 ||
            rsp_valid !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got op=%b rdy=%b busy=%b rv=%b err=%b expected op=110 rdy=1 busy=0 rv=0 err=0",
                     cpu_op, cmd_ready, busy, rsp_valid, err);
        end
        vectors++;
        if (cpu_ram_addr !== 9'd0 || cpu_ram_cnt !== 4'd0 || cpu_reg_sel !== 2'd0 ||
            cpu_ram_input[0] !== 32'd0 || rsp_data[0] !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data got addr=%h cnt=%h sel=%h in0=%h rd0=%h expected all 0",
                     cpu_ram_addr, cpu_ram_cnt, cpu_reg_sel, cpu_ram_input[0], rsp_data[0]);
        end
    endtask

    task automatic test_write();
        int n = 0;
        logic [8:0] a = '0;
        logic [31:0] d = '0;
        logic [3:0] c = '0;
        push(3'b101, 9'h010, 4'd4, 32'hDEADBEEF);
        for (int i = 0; i < 10; i++) begin
            if (cpu_op === 3'b101) begin
                n++;
                a = cpu_ram_addr;
                d = cpu_ram_input[0];
                c = cpu_ram_cnt;
            end
            @(negedge clk);
        end
        vectors++;
        if (n != 1) begin
            miscompares++;
            $display("FAIL write_pulse got %0d cycles expected 1", n);
        end
        vectors++;
        if (a !== 9'h010 || d !== 32'hDEADBEEF || c !== 4'd4) begin
            miscompares++;
            $display("FAIL write_fields got addr=%h cnt=%h in0=%h expected addr=010 cnt=4 in0=deadbeef",
                     a, c, d);
        end
    endtask

    task automatic test_read();
        int n = 0;
        use_w0 = 1'b1;
        w0 = 32'hDEADBEEF;
        rsp_ready = 1'b0;
        push(3'b100, 9'h010, 4'd4, 32'h0);
        for (int i = 0; i < 12; i++) begin
            if (cpu_op === 3'b100) n++;
            if (rsp_valid === 1'b1) break;
            @(negedge clk);
        end
        vectors++;
        if (n != 2 || rsp_valid !== 1'b1 || rsp_data[0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL read_capture got rd_cycles=%0d rv=%b rd0=%h expected 2 1 deadbeef",
                     n, rsp_valid, rsp_data[0]);
        end
        w0 = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_data[0] !== 32'hDEADBEEF || cpu_op !== 3'b110) begin
                miscompares++;
                $display("FAIL read_stall got rv=%b rd0=%h op=%b expected 1 deadbeef 110",
                         rsp_valid, rsp_data[0], cpu_op);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL read_release got rv=%b busy=%b expected 0 0", rsp_valid, busy);
        end
        use_w0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [8:0] got[$];
        push(3'b100, 9'h1E0, 4'd1, 32'h0);
        for (int i = 0; i < 10 && rsp_valid !== 1'b1; i++) @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_stall got rv=%b expected 1", rsp_valid);
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (cmd_ready !== (k < 4)) begin
                miscompares++;
                $display("FAIL b2b_ready%0d got %b expected %b", k, cmd_ready, k < 4);
            end
            cmd_instr = {3'b010, 2'b10, 9'(32'h20 + k), 4'd2};
            for (int i = 0; i < 16; i++) cmd_wdata[i] = $urandom;
            cmd_valid = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_full got %b expected 0", cmd_ready);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (cpu_op !== NOP) got.push_back(cpu_ram_addr);
            @(negedge clk);
        end
        vectors++;
        if (got.size() != 4) begin
            miscompares++;
            $display("FAIL b2b_count got %0d expected 4", got.size());
        end
        for (int k = 0; k < got.size() && k < 4; k++) begin
            vectors++;
            if (got[k] !== 9'(32'h20 + k)) begin
                miscompares++;
                $display("FAIL b2b_order%0d got %h expected %h", k, got[k], 9'(32'h20 + k));
            end
        end
    endtask

    task automatic test_simul_push_pop();
        logic [8:0] got[$];
        int k = 3;
        int pairs = 0;
        int extra = 0;
        push(3'b100, 9'h1F0, 4'd1, 32'h0);
        for (int i = 0; i < 10 && rsp_valid !== 1'b1; i++) @(negedge clk);
        for (int j = 0; j < 3; j++) push(3'b001, 9'(32'h100 + j), 4'd1, 32'h0);
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            cmd_valid = 1'b0;
            if (cpu_op !== NOP) got.push_back(cpu_ram_addr);
            if (extra == 1) begin
                vectors++;
                if (cmd_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL simul_full got %b expected 0", cmd_ready);
                end
                extra = 2;
            end else if (pairs < 20 && cpu_op === NOP) begin
                vectors++;
                if (cmd_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL simul_ready%0d got %b expected 1", pairs, cmd_ready);
                end
                cmd_instr = {3'b001, 2'b00, 9'(32'h100 + k), 4'd1};
                cmd_valid = 1'b1;
                k++;
                pairs++;
            end else if (pairs == 20 && extra == 0 && cpu_op !== NOP) begin
                cmd_instr = {3'b001, 2'b00, 9'(32'h100 + k), 4'd1};
                cmd_valid = 1'b1;
                k++;
                extra = 1;
            end
            if (got.size() >= 24 && extra == 2) break;
        end
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (got.size() != 24) begin
            miscompares++;
            $display("FAIL simul_count got %0d expected 24", got.size());
        end
        for (int j = 0; j < got.size() && j < 24; j++) begin
            vectors++;
            if (got[j] !== 9'(32'h100 + j)) begin
                miscompares++;
                $display("FAIL simul_order%0d got %h expected %h", j, got[j], 9'(32'h100 + j));
            end
        end
    endtask

    task automatic test_reset_capture();
        bit found = 0;
        push(3'b100, 9'h055, 4'd3, 32'h0);
        push(3'b001, 9'h056, 4'd1, 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (cpu_op === 3'b100) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        vectors++;
        if (!found || cpu_op !== 3'b100) begin
            miscompares++;
            $display("FAIL rstcap_reach got op=%b found=%0d expected 100 1", cpu_op, found);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (cpu_op !== NOP || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstcap_async got op=%b rv=%b busy=%b expected 110 0 0",
                     cpu_op, rsp_valid, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (cpu_op !== NOP || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL rstcap_after got op=%b rv=%b busy=%b rdy=%b expected 110 0 0 1",
                         cpu_op, rsp_valid, busy, cmd_ready);
            end
        end
    endtask

    task automatic test_illegal();
        int n = 0;
        push(3'b111, 9'h033, 4'd1, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (cpu_op === 3'b111) n++;
            @(negedge clk);
        end
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        vectors++;
        if (n != 0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_trap got cycles=%0d err=%b expected 0 1", n, err);
        end
`else
        vectors++;
        if (n != 1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_nop got cycles=%0d err=%b expected 1 0", n, err);
        end
`endif
    endtask

    task automatic test_random_traffic();
        cmd_t q[$];
        cmd_t c;
        logic [2:0] ops[$];
        logic [2:0] op;
        logic [8:0] raddr = '0;
        int acc = 0;
        int iss = 0;
        bit exp_hold = 0;
        bit exp_nop = 0;
        bit rsp_pend = 0;
        bit done = 0;
        bit drain;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
`else
        ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
`endif
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== rsp_pend ||
                (rsp_pend && (rsp_data[0] !== pat(raddr, 0) ||
                              rsp_data[15] !== pat(raddr, 15)))) begin
                miscompares++;
                $display("FAIL rnd_rsp got rv=%b rd0=%h expected rv=%b rd0=%h",
                         rsp_valid, rsp_data[0], rsp_pend, pat(raddr, 0));
            end
            if (exp_hold) begin
                vectors++;
                if (cpu_op !== 3'b100 || cpu_ram_addr !== raddr) begin
                    miscompares++;
                    $display("FAIL rnd_hold got op=%b addr=%h expected 100 %h",
                             cpu_op, cpu_ram_addr, raddr);
                end
                exp_hold = 0;
                rsp_pend = 1;
            end else if (exp_nop) begin
                vectors++;
                if (cpu_op !== NOP) begin
                    miscompares++;
                    $display("FAIL rnd_pulse got op=%b expected 110", cpu_op);
                end
                exp_nop = 0;
            end else if (cpu_op !== NOP) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd_spurious got op=%b expected none", cpu_op);
                end else begin
                    c = q.pop_front();
                    iss++;
                    if ({cpu_op, cpu_reg_sel, cpu_ram_addr, cpu_ram_cnt} !== c.instr ||
                        cpu_ram_input[0] !== c.w0 || cpu_ram_input[15] !== c.w15) begin
                        miscompares++;
                        $display("FAIL rnd_issue got %h/%h expected %h/%h",
                                 {cpu_op, cpu_reg_sel, cpu_ram_addr, cpu_ram_cnt},
                                 cpu_ram_input[0], c.instr, c.w0);
                    end
                    if (c.instr[17:15] == 3'b100) begin
                        exp_hold = 1;
                        raddr = c.instr[12:4];
                    end else begin
                        exp_nop = 1;
                    end
                end
            end
            vectors++;
            if (cmd_ready !== ((acc - iss) < DEPTH)) begin
                miscompares++;
                $display("FAIL rnd_ready got %b expected %b", cmd_ready, (acc - iss) < DEPTH);
            end
            drain = (cyc >= 600);
            rsp_ready = drain ? 1'b1 : (($urandom % 3) == 0);
            if (rsp_valid === 1'b1 && rsp_ready) rsp_pend = 0;
            op = ops[$urandom % ops.size()];
            cmd_instr = {op, 2'($urandom), 9'($urandom), 4'($urandom)};
            for (int i = 0; i < 16; i++) cmd_wdata[i] = $urandom;
            cmd_valid = !drain && (($urandom % 2) == 1);
            if (cmd_valid && cmd_ready === 1'b1) begin
                c.instr = cmd_instr;
                c.w0 = cmd_wdata[0];
                c.w15 = cmd_wdata[15];
                q.push_back(c);
                acc++;
            end
            if (drain && q.size() == 0 && !exp_hold && !exp_nop && !rsp_pend &&
                busy === 1'b0 && rsp_valid === 1'b0)
                done = 1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL rnd_drain got pending=%0d busy=%b expected 0 0", q.size(), busy);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_instr = '0;
        for (int i = 0; i < 16; i++) cmd_wdata[i] = '0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_simul_push_pop();
        test_reset_capture();
        apply_reset();
        test_illegal();
        apply_reset();
        test_random_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
